// File: rtl/hd44780_lcd_responder.sv
// HD44780-compatible display-side receiver: decodes LCD_EN falling edges into instruction/data
// writes on an 80-byte DDRAM, tracks AC/flags/busy time, and offers a registered 16x2 read port.
module hd44780_lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       iRD_ROW,
  input  logic [3:0] iRD_COL,
  output logic [7:0] oRD_CHAR,
  output logic [6:0] oAC,
  output logic       oDISP_ON,
  output logic       oCURSOR_ON,
  output logic       oBLINK_ON,
  output logic       oTWO_LINE,
  output logic       oBUSY,
  output logic       oCMD_STROBE,
  output logic       oDATA_STROBE,
  output logic       oERR,
  input  logic       iERR_CLR
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [6:0] LAST_IDX = 7'd79;
  localparam logic [6:0] BAD_IDX  = 7'h7F;

  typedef enum logic [1:0] {ST_INIT_CLR, ST_IDLE, ST_CLEARING, ST_BUSY_WAIT} state_e;

  state_e           state_q, state_d;
  logic             en_s1_q, en_s1_d, en_s2_q, en_s2_d;
  logic             rs_s1_q, rs_s1_d, rs_s2_q, rs_s2_d;
  logic             rw_s1_q, rw_s1_d, rw_s2_q, rw_s2_d;
  logic [7:0]       dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic             cmd_vld_q, cmd_vld_d, cmd_rs_q, cmd_rs_d;
  logic [7:0]       cmd_dat_q, cmd_dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       fill_q, fill_d;
  logic             busy_q, busy_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d, cg_q, cg_d;
  logic             disp_q, disp_d, cur_q, cur_d, blk_q, blk_d, two_q, two_d;
  logic             err_q, err_d;
  logic [7:0]       rd_char_q, rd_char_d;

  logic [7:0]       mem_q [80];
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  logic             en_fall, bus_err, is_clear, cmd_err;
  logic [6:0]       ac_idx, rd_idx;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up, input logic two);
    if (two) begin
      if (up) return (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
      else    return (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    end
    if (up) return (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
    return (ac == 7'h00) ? 7'h4F : ac - 7'd1;
  endfunction

  function automatic logic [6:0] idx_of(input logic [6:0] ac, input logic two);
    if (two) begin
      if (ac < 7'h28) return ac;
      if (ac >= 7'h40 && ac < 7'h68) return ac - 7'd24;
      return BAD_IDX;
    end
    return (ac <= 7'h4F) ? ac : BAD_IDX;
  endfunction

  function automatic logic addr_ok(input logic [6:0] a, input logic two);
    if (two) return (a < 7'h28) || (a >= 7'h40 && a < 7'h68);
    return a <= 7'h4F;
  endfunction

  // Bus synchroniser and command capture; a fall counts only with EN seen high in s2.
  always_comb begin
    en_s1_d  = LCD_EN;
    rs_s1_d  = LCD_RS;
    rw_s1_d  = LCD_RW;
    dat_s1_d = LCD_DATA;
    en_s2_d  = en_s1_q;
    rs_s2_d  = rs_s1_q;
    rw_s2_d  = rw_s1_q;
    dat_s2_d = dat_s1_q;
    en_fall  = en_s2_q & ~en_s1_q;
    bus_err  = en_fall & ~rw_s2_q & (busy_q | cmd_vld_q);
    cmd_vld_d = en_fall & ~rw_s2_q & ~busy_q & ~cmd_vld_q;
    cmd_rs_d  = cmd_vld_d ? rs_s2_q  : cmd_rs_q;
    cmd_dat_d = cmd_vld_d ? dat_s2_q : cmd_dat_q;
  end

  assign is_clear = ~cmd_rs_q & (cmd_dat_q == 8'h01);
  assign ac_idx   = idx_of(ac_q, two_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_CLR:  if (fill_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:      if (cmd_vld_q) state_d = is_clear ? ST_CLEARING : ST_BUSY_WAIT;
      ST_CLEARING,
      ST_BUSY_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default:      state_d = ST_INIT_CLR;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    busy_d    = busy_q;
    ac_d      = ac_q;
    id_d      = id_q;
    cg_d      = cg_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blk_d     = blk_q;
    two_d     = two_q;
    mem_we    = 1'b0;
    mem_waddr = fill_q;
    mem_wdata = 8'h20;
    cmd_err   = 1'b0;
    case (state_q)
      ST_INIT_CLR: begin
        mem_we = 1'b1;
        fill_d = fill_q + 7'd1;
        if (fill_q == LAST_IDX) busy_d = 1'b0;
      end
      ST_CLEARING, ST_BUSY_WAIT: begin
        // Fill runs alongside the busy count; CLEAR_CYCLES >= 80 lets it finish.
        if (state_q == ST_CLEARING && fill_q <= LAST_IDX) begin
          mem_we = 1'b1;
          fill_d = fill_q + 7'd1;
        end
        if (cnt_q == '0) busy_d = 1'b0;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        if (cmd_vld_q) begin
          busy_d = 1'b1;
          cnt_d  = BUSY_LOAD;
          if (cmd_rs_q) begin
            if (!cg_q) begin
              mem_we    = (ac_idx <= LAST_IDX);
              mem_waddr = ac_idx;
              mem_wdata = cmd_dat_q;
              ac_d      = ac_step(ac_q, id_q, two_q);
            end
          end else begin
            casez (cmd_dat_q)
              8'b1???????: begin
                cg_d = 1'b0;
                if (addr_ok(cmd_dat_q[6:0], two_q)) ac_d = cmd_dat_q[6:0];
                else                                cmd_err = 1'b1;
              end
              8'b01??????: cg_d = 1'b1;
              8'b001?????: two_d = cmd_dat_q[3];
              8'b0001????: if (!cmd_dat_q[3]) ac_d = ac_step(ac_q, cmd_dat_q[2], two_q);
              8'b00001???: {disp_d, cur_d, blk_d} = cmd_dat_q[2:0];
              8'b000001??: id_d = cmd_dat_q[1];
              8'b0000001?: ac_d = 7'h00;
              8'b00000001: begin
                ac_d   = 7'h00;
                id_d   = 1'b1;
                fill_d = 7'h00;
                cnt_d  = CLEAR_LOAD;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
    // A new error in the same cycle as a clear request wins.
    err_d = (bus_err | cmd_err) ? 1'b1 : (iERR_CLR ? 1'b0 : err_q);
    rd_idx    = iRD_ROW ? (7'd40 + {3'b000, iRD_COL}) : {3'b000, iRD_COL};
    rd_char_d = (iRD_ROW & ~two_q) ? 8'h20 : mem_q[rd_idx];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_INIT_CLR;
      en_s1_q   <= 1'b0;  en_s2_q  <= 1'b0;
      rs_s1_q   <= 1'b0;  rs_s2_q  <= 1'b0;
      rw_s1_q   <= 1'b0;  rw_s2_q  <= 1'b0;
      dat_s1_q  <= 8'h00; dat_s2_q <= 8'h00;
      cmd_vld_q <= 1'b0;
      cmd_rs_q  <= 1'b0;
      cmd_dat_q <= 8'h00;
      cnt_q     <= '0;
      fill_q    <= 7'h00;
      busy_q    <= 1'b1;
      ac_q      <= 7'h00;
      id_q      <= 1'b1;
      cg_q      <= 1'b0;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      blk_q     <= 1'b0;
      two_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_char_q <= 8'h20;
    end else begin
      state_q   <= state_d;
      en_s1_q   <= en_s1_d;  en_s2_q  <= en_s2_d;
      rs_s1_q   <= rs_s1_d;  rs_s2_q  <= rs_s2_d;
      rw_s1_q   <= rw_s1_d;  rw_s2_q  <= rw_s2_d;
      dat_s1_q  <= dat_s1_d; dat_s2_q <= dat_s2_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_rs_q  <= cmd_rs_d;
      cmd_dat_q <= cmd_dat_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      busy_q    <= busy_d;
      ac_q      <= ac_d;
      id_q      <= id_d;
      cg_q      <= cg_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      blk_q     <= blk_d;
      two_q     <= two_d;
      err_q     <= err_d;
      rd_char_q <= rd_char_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign oRD_CHAR     = rd_char_q;
  assign oAC          = ac_q;
  assign oDISP_ON     = disp_q;
  assign oCURSOR_ON   = cur_q;
  assign oBLINK_ON    = blk_q;
  assign oTWO_LINE    = two_q;
  assign oBUSY        = busy_q;
  assign oCMD_STROBE  = cmd_vld_q & ~cmd_rs_q;
  assign oDATA_STROBE = cmd_vld_q & cmd_rs_q;
  assign oERR         = err_q;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed plus randomized bench for hd44780_lcd_responder; the reference model treats the
// address space as an 80-position ring and recomputes AC and DDRAM contents from that.
module tb_hd44780_lcd_responder;
  localparam int BUSY  = 40;
  localparam int CLEAR = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lcd_data;
  logic       lcd_rw, lcd_en, lcd_rs;
  logic       rd_row;
  logic [3:0] rd_col;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, two_line, busy, cmd_stb, dat_stb, err, err_clr;

  int n_chk = 0;
  int n_fail = 0;
  int n_cmd = 0;
  int n_dat = 0;

  logic [7:0] m_mem [80];
  int   m_ac;
  logic m_id, m_cg, m_two, m_disp, m_cur, m_blk, m_err;

  hd44780_lcd_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .iCLK(clk), .iRST_N(rst_n), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .LCD_RS(lcd_rs), .iRD_ROW(rd_row), .iRD_COL(rd_col), .oRD_CHAR(rd_char), .oAC(ac),
    .oDISP_ON(disp_on), .oCURSOR_ON(cursor_on), .oBLINK_ON(blink_on), .oTWO_LINE(two_line),
    .oBUSY(busy), .oCMD_STROBE(cmd_stb), .oDATA_STROBE(dat_stb), .oERR(err), .iERR_CLR(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_stb) n_cmd++;
    if (dat_stb) n_dat++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ring position <-> AC value: line 2 lives at positions 40..79 in two-line mode.
  function automatic int pos_of(input int a);
    if (m_two && a >= 64) return a - 64 + 40;
    return a;
  endfunction
  function automatic int ac_of(input int p);
    if (m_two && p >= 40) return p - 40 + 64;
    return p;
  endfunction
  function automatic int moved(input int a, input logic up);
    return ac_of((pos_of(a) + (up ? 1 : 79)) % 80);
  endfunction
  function automatic logic addr_valid(input int a);
    if (m_two) return (a < 40) || (a >= 64 && a < 104);
    return a < 80;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_cg = 0; m_two = 0;
    m_disp = 0; m_cur = 0; m_blk = 0; m_err = 0;
  endtask

  task automatic model_exec(input logic rs, input logic [7:0] d);
    if (rs) begin
      if (!m_cg) begin
        m_mem[pos_of(m_ac)] = d;
        m_ac = moved(m_ac, m_id);
      end
    end else if (d >= 8'h80) begin
      m_cg = 0;
      if (addr_valid(int'(d) - 128)) m_ac = int'(d) - 128;
      else m_err = 1;
    end else if (d >= 8'h40) m_cg = 1;
    else if (d >= 8'h20) m_two = d[3];
    else if (d >= 8'h10) begin
      if (!d[3]) m_ac = moved(m_ac, d[2]);
    end else if (d >= 8'h08) {m_disp, m_cur, m_blk} = d[2:0];
    else if (d >= 8'h04) m_id = d[1];
    else if (d >= 8'h02) m_ac = 0;
    else if (d == 8'h01) begin
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      m_ac = 0; m_id = 1;
    end
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_en = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (4) @(posedge clk);
    for (int i = 0; i < CLEAR + 100 && busy; i++) @(negedge clk);
    @(negedge clk);
    chk("wait_idle", busy, 0);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    pulse(rs, 1'b0, d);
    model_exec(rs, d);
    wait_idle();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ac"}, ac, m_ac);
    chk({tag, "_flags"}, {disp_on, cursor_on, blink_on, two_line}, {m_disp, m_cur, m_blk, m_two});
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        rd_row = r[0]; rd_col = c[3:0];
        @(posedge clk); @(negedge clk);
        e = (r == 0) ? m_mem[c] : (m_two ? m_mem[40 + c] : 8'h20);
        chk($sformatf("%s_r%0dc%0d", tag, r, c), rd_char, e);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ac"}, ac, 0);
    chk({tag, "_flags"}, {disp_on, cursor_on, blink_on, two_line}, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_strobes"}, {cmd_stb, dat_stb}, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdchar"}, rd_char, 8'h20);
  endtask

  task automatic release_and_init(input string tag);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (79) @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_before_80"}, busy, 1);
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_after_80"}, busy, 0);
  endtask

  task automatic clr_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    m_err = 0;
    @(negedge clk);
    chk("err_clear", err, 0);
  endtask

  task automatic random_ops(input int n, input string tag);
    int k, p;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6) wr(1'b1, 8'($urandom_range(0, 255)));
      else if (k == 6) wr(1'b0, {6'b000001, 1'($urandom_range(0, 1)), 1'b0});
      else if (k == 7) wr(1'b0, {5'b00010, 1'($urandom_range(0, 1)), 2'b00});
      else if (k == 8) begin
        p = $urandom_range(0, 79);
        d = 8'h80 | 8'(ac_of(p));
        wr(1'b0, d);
      end else wr(1'b0, {5'b00001, 3'($urandom_range(0, 7))});
      chk($sformatf("%s_ac_%0d", tag, i), ac, m_ac);
    end
  endtask

  initial begin
    int cmd0, dat0, hi;
    rst_n = 1'b0; lcd_data = 8'h00; lcd_rw = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0;
    rd_row = 1'b0; rd_col = 4'd0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");

    release_and_init("init");
    check_all("init");
    check_regs("init");

    cmd0 = n_cmd; dat0 = n_dat;
    wr(1'b0, 8'h38); wr(1'b0, 8'h0C); wr(1'b0, 8'h06); wr(1'b0, 8'h80);
    wr(1'b1, 8'h48); wr(1'b1, 8'h69);
    check_regs("hello");
    chk("hello_ac_is_2", ac, 7'h02);
    chk("hello_cmd_strobes", n_cmd - cmd0, 4);
    chk("hello_dat_strobes", n_dat - dat0, 2);
    check_all("hello");

    wr(1'b0, 8'hA7); wr(1'b1, 8'h41);
    chk("wrap_27_to_40", ac, 7'h40);
    wr(1'b0, 8'h04); wr(1'b0, 8'hC0); wr(1'b1, 8'h42);
    chk("wrap_40_to_27", ac, 7'h27);
    check_all("wrap");

    // Second data fall arrives 10 cycles after the first, inside the busy window.
    wr(1'b0, 8'h06); wr(1'b0, 8'h85);
    dat0 = n_dat;
    pulse(1'b1, 1'b0, 8'h58);
    model_exec(1'b1, 8'h58);
    repeat (6) @(posedge clk);
    pulse(1'b1, 1'b0, 8'h59);
    m_err = 1;
    wait_idle();
    check_regs("busy_err");
    chk("busy_err_one_strobe", n_dat - dat0, 1);
    check_all("busy_err");
    clr_err();

    pulse(1'b0, 1'b0, 8'h01);
    model_exec(1'b0, 8'h01);
    hi = 0;
    @(negedge clk);
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    for (int i = 0; i < CLEAR + 50 && busy; i++) begin hi++; @(negedge clk); end
    chk("clear_busy_cycles", hi, CLEAR);
    check_all("clear");
    check_regs("clear");

    wr(1'b1, 8'h5A);
    pulse(1'b0, 1'b0, 8'h01);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midclear_reset");
    model_reset();
    release_and_init("reinit");
    check_all("reinit");
    check_regs("reinit");

    wr(1'b0, 8'h38); wr(1'b0, 8'h0C); wr(1'b0, 8'h06);
    wr(1'b1, 8'h31); wr(1'b1, 8'h32);
    cmd0 = n_cmd; dat0 = n_dat;
    pulse(1'b1, 1'b1, 8'h55);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("read_cycle_no_strobe", (n_cmd - cmd0) + (n_dat - dat0), 0);
    check_regs("read_cycle");
    check_all("read_cycle");
    wr(1'b0, 8'hB0);
    chk("bad_addr_ac_kept", ac, 7'h02);
    chk("bad_addr_err", err, 1);
    check_regs("bad_addr");
    clr_err();

    dat0 = n_dat;
    wr(1'b0, 8'h40); wr(1'b1, 8'h77);
    chk("cg_data_strobe", n_dat - dat0, 1);
    check_regs("cg_mode");
    wr(1'b0, 8'h80);

    random_ops(60, "rnd2");
    check_all("rnd2");
    check_regs("rnd2");

    wr(1'b0, 8'h30); wr(1'b0, 8'h80);
    random_ops(40, "rnd1");
    check_all("rnd1");
    check_regs("rnd1");
    wr(1'b0, 8'hD0);
    check_regs("bad_addr_1line");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
